// File: rtl/pe_accumulator_if.sv
// Job/product/result bundle between the PE, the accumulator and the output stage.
// Parameters must match the pe_accumulator instance the bundle is bound to.
interface pe_accumulator_if #(
    parameter int PROD_W = 19,
    parameter int ACC_W  = 32,
    parameter int LEN_W  = 8
);
    // Handshakes: a job is taken on a cycle with i_start & o_start_ready.
    // A product is taken on a cycle with i_prod_valid while o_busy.
    // A result is consumed on a cycle with o_acc_valid & i_acc_ready.
    // o_acc/o_overflow stay stable while o_acc_valid is high and i_acc_ready is low.
    logic              i_start;
    logic [LEN_W-1:0]  i_len;
    logic              o_start_ready;
    logic              i_prod_valid;
    logic [PROD_W-1:0] i_prod;
    logic              o_busy;
    logic              o_acc_valid;
    logic              i_acc_ready;
    logic [ACC_W-1:0]  o_acc;
    logic              o_overflow;
    logic [1:0]        o_dbg_state;

    modport slave (
        input  i_start, i_len, i_prod_valid, i_prod, i_acc_ready,
        output o_start_ready, o_busy, o_acc_valid, o_acc, o_overflow, o_dbg_state
    );

    modport master (
        output i_start, i_len, i_prod_valid, i_prod, i_acc_ready,
        input  o_start_ready, o_busy, o_acc_valid, o_acc, o_overflow, o_dbg_state
    );
endinterface

// File: rtl/pe_accumulator.sv
// Sums a programmed number of signed PE partial products and hands the result on.
// Define PE_ACC_SAT_EN to clamp on overflow instead of wrapping.
module pe_accumulator #(
    parameter int PROD_W = 19,
    parameter int ACC_W  = 32,
    parameter int LEN_W  = 8
) (
    input logic             i_clk,
    input logic             i_rst,
    pe_accumulator_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [LEN_W:0] FULL_LEN = {1'b1, {LEN_W{1'b0}}};
    localparam logic [LEN_W:0] ONE      = {{LEN_W{1'b0}}, 1'b1};
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t           state, state_n;
    logic [ACC_W-1:0] acc, acc_n;
    logic             ovf, ovf_n;
    logic [LEN_W:0]   count, count_n;

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] add_res;
    logic             add_ovf;
    logic [LEN_W:0]   len_count;
    logic             start_ready;
    logic             busy;
    logic             acc_valid;

    assign prod_ext  = {{(ACC_W-PROD_W){bus.i_prod[PROD_W-1]}}, bus.i_prod};
    assign sum       = acc + prod_ext;
    // Signed overflow: operands agree in sign, the sum does not.
    assign add_ovf   = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
    assign len_count = (bus.i_len == '0) ? FULL_LEN : {1'b0, bus.i_len};

`ifdef PE_ACC_SAT_EN
    assign add_res = add_ovf ? (acc[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum;
`else
    assign add_res = sum;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            acc   <= '0;
            ovf   <= 1'b0;
            count <= '0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            ovf   <= ovf_n;
            count <= count_n;
        end
    end

    always_comb begin
        state_n     = state;
        acc_n       = acc;
        ovf_n       = ovf;
        count_n     = count;
        start_ready = 1'b0;
        busy        = 1'b0;
        acc_valid   = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (bus.i_start) begin
                    state_n = ACC;
                    acc_n   = '0;
                    ovf_n   = 1'b0;
                    count_n = len_count;
                end
            end
            ACC: begin
                busy = 1'b1;
                if (bus.i_prod_valid) begin
                    acc_n   = add_res;
                    ovf_n   = ovf | add_ovf;
                    count_n = count - ONE;
                    if (count == ONE) state_n = HOLD;
                end
            end
            HOLD: begin
                acc_valid   = 1'b1;
                start_ready = bus.i_acc_ready;
                if (bus.i_acc_ready) begin
                    // Consume and restart in the same cycle so back-to-back jobs have no bubble.
                    if (bus.i_start) begin
                        state_n = ACC;
                        acc_n   = '0;
                        ovf_n   = 1'b0;
                        count_n = len_count;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.o_start_ready = start_ready;
    assign bus.o_busy        = busy;
    assign bus.o_acc_valid   = acc_valid;
    assign bus.o_acc         = acc;
    assign bus.o_overflow    = ovf;
    assign bus.o_dbg_state   = state;
endmodule

// File: tb/tb_pe_accumulator.sv
// Directed bench for pe_accumulator (ACC_W=20 so overflow is reachable),
// with a per-cycle compare against an arithmetic job model.
module tb_pe_accumulator;
  localparam int PROD_W = 19;
  localparam int ACC_W  = 20;
  localparam int LEN_W  = 8;

  logic clk;
  logic rst;
  pe_accumulator_if #(.PROD_W(PROD_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) bus ();

  pe_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int passed = 0;
  bit cmp_en = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // model: jobs as remaining-product counters and a queue of finished results
  logic [ACC_W:0] exp_q[$];   // {overflow, result}
  longint run_sum;
  bit     run_ovf;
  int     remaining;

  function automatic void model_add(input longint p);
    longint s;
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (ACC_W-1)) - 1;
    lo = -(longint'(1) <<< (ACC_W-1));
    s  = run_sum + p;
    if (s > hi || s < lo) begin
      run_ovf = 1;
`ifdef PE_ACC_SAT_EN
      s = (s > hi) ? hi : lo;
`else
      s = (s > hi) ? s - (longint'(1) <<< ACC_W) : s + (longint'(1) <<< ACC_W);
`endif
    end
    run_sum = s;
  endfunction

  always @(posedge clk) begin
    bit m_valid;
    bit m_busy;
    bit m_sr;
    logic [ACC_W-1:0] r;
    if (rst) begin
      exp_q.delete();
      remaining = 0;
      run_sum = 0;
      run_ovf = 0;
    end else begin
      m_valid = (exp_q.size() != 0);
      m_busy  = (remaining != 0);
      m_sr    = !m_busy && (!m_valid || bus.i_acc_ready);
      if (m_valid && bus.i_acc_ready) void'(exp_q.pop_front());
      if (m_busy && bus.i_prod_valid) begin
        model_add(longint'($signed(bus.i_prod)));
        remaining--;
        if (remaining == 0) begin
          r = run_sum[ACC_W-1:0];
          exp_q.push_back({run_ovf, r});
        end
      end
      if (bus.i_start && m_sr) begin
        remaining = (bus.i_len == 0) ? (1 << LEN_W) : int'(bus.i_len);
        run_sum = 0;
        run_ovf = 0;
      end
    end
  end

  // compare process, away from the active edge
  always @(negedge clk) begin
    bit e_valid;
    bit e_busy;
    logic [ACC_W:0] e;
    if (cmp_en && !rst) begin
      e_valid = (exp_q.size() != 0);
      e_busy  = (remaining != 0);
      chk("cyc_valid", longint'(bus.o_acc_valid), longint'(e_valid));
      chk("cyc_busy", longint'(bus.o_busy), longint'(e_busy));
      chk("cyc_start_ready", longint'(bus.o_start_ready),
          longint'(!e_busy && (!e_valid || bus.i_acc_ready)));
      if (e_valid) begin
        e = exp_q[0];
        chk("cyc_acc", longint'($signed(bus.o_acc)), longint'($signed(e[ACC_W-1:0])));
        chk("cyc_overflow", longint'(bus.o_overflow), longint'(e[ACC_W]));
      end
    end
  end

  // driver tasks: inputs change 1 time unit after the active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int len);
    bus.i_start = 1'b1;
    bus.i_len   = LEN_W'(len);
    tick();
    bus.i_start = 1'b0;
  endtask

  task automatic send(input int p);
    bus.i_prod_valid = 1'b1;
    bus.i_prod       = PROD_W'(p);
    tick();
    bus.i_prod_valid = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, longint'(bus.o_acc_valid), 0);
    chk({tag, "_busy"}, longint'(bus.o_busy), 0);
    chk({tag, "_start_ready"}, longint'(bus.o_start_ready), 1);
  endtask

  initial begin
    longint ovf_exp;
    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_len = '0;
    bus.i_prod_valid = 1'b0;
    bus.i_prod = '0;
    bus.i_acc_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    cmp_en = 1'b1;
    chk_idle("reset");
    chk("reset_acc", longint'($signed(bus.o_acc)), 0);
    chk("reset_overflow", longint'(bus.o_overflow), 0);

    // basic sum, latency 1, single-cycle result
    bus.i_acc_ready = 1'b1;
    start_job(4);
    send(10); send(-3); send(100); send(-200);
    chk("basic_valid", longint'(bus.o_acc_valid), 1);
    chk("basic_acc", longint'($signed(bus.o_acc)), -93);
    chk("basic_overflow", longint'(bus.o_overflow), 0);
    tick();
    chk_idle("basic_after");

    // stalls and backpressure; start during HOLD is ignored
    bus.i_acc_ready = 1'b0;
    start_job(3);
    send(5); tick(); tick(); send(7); send(9);
    for (int i = 0; i < 5; i++) begin
      bus.i_start = (i == 2);
      bus.i_len   = 8'd2;
      chk("bp_valid", longint'(bus.o_acc_valid), 1);
      chk("bp_acc", longint'($signed(bus.o_acc)), 21);
      chk("bp_start_ready", longint'(bus.o_start_ready), 0);
      tick();
    end
    bus.i_start = 1'b0;
    bus.i_acc_ready = 1'b1;
    tick();
    chk_idle("bp_after");

    // back-to-back: consume and restart in the same cycle
    bus.i_acc_ready = 1'b0;
    start_job(1);
    send(4);
    chk("b2b_first_acc", longint'($signed(bus.o_acc)), 4);
    bus.i_acc_ready = 1'b1;
    start_job(2);
    chk("b2b_no_idle_busy", longint'(bus.o_busy), 1);
    chk("b2b_no_idle_valid", longint'(bus.o_acc_valid), 0);
    send(1); send(1);
    chk("b2b_second_valid", longint'(bus.o_acc_valid), 1);
    chk("b2b_second_acc", longint'($signed(bus.o_acc)), 2);
    tick();

    // length zero means 256 products
    start_job(0);
    for (int i = 0; i < 255; i++) send(1);
    chk("len0_255_valid", longint'(bus.o_acc_valid), 0);
    chk("len0_255_busy", longint'(bus.o_busy), 1);
    send(1);
    chk("len0_valid", longint'(bus.o_acc_valid), 1);
    chk("len0_acc", longint'($signed(bus.o_acc)), 256);
    tick();

    // overflow with max positive products
`ifdef PE_ACC_SAT_EN
    ovf_exp = 524287;
`else
    ovf_exp = -4;
`endif
    start_job(4);
    for (int i = 0; i < 4; i++) send(262143);
    chk("ovf_acc", longint'($signed(bus.o_acc)), ovf_exp);
    chk("ovf_flag", longint'(bus.o_overflow), 1);
    tick();
    start_job(1);
    send(-7);
    chk("ovf_cleared_flag", longint'(bus.o_overflow), 0);
    chk("ovf_cleared_acc", longint'($signed(bus.o_acc)), -7);
    tick();

    // reset mid-job discards the partial sum
    start_job(4);
    send(3); send(4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("midrst");
    chk("midrst_acc", longint'($signed(bus.o_acc)), 0);
    send(5); send(6);
    chk_idle("midrst_ignored");
    chk("midrst_ignored_acc", longint'($signed(bus.o_acc)), 0);
    tick();

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
